// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Accepted keys are decoded to hex and shifted into a two-digit history for the display mux.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 24000,
  parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [DB_W-1:0]  db_cnt;
  logic [3:0]       sync1;
  logic [3:0]       rs;
  logic [1:0]       r_q;
  logic [1:0]       c_q;
  logic [1:0]       row_idx_c;
  logic [1:0]       col_idx_c;
  logic [3:0]       code_c;
  logic             row_up_c;

  // Two-flop synchronizer; idles at "no key" so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 4'b1111;
      rs    <= 4'b1111;
    end else begin
      sync1 <= row;
      rs    <= sync1;
    end
  end

  // Lowest pressed row wins; column index follows the driven zero.
  always_comb begin
    row_idx_c = 2'd0;
    if (!rs[0])      row_idx_c = 2'd0;
    else if (!rs[1]) row_idx_c = 2'd1;
    else if (!rs[2]) row_idx_c = 2'd2;
    else if (!rs[3]) row_idx_c = 2'd3;

    col_idx_c = 2'd0;
    case (col)
      4'b1110: col_idx_c = 2'd0;
      4'b1101: col_idx_c = 2'd1;
      4'b1011: col_idx_c = 2'd2;
      4'b0111: col_idx_c = 2'd3;
      default: col_idx_c = 2'd0;
    endcase

    row_up_c = rs[r_q];
  end

  // Keypad legend for the latched (row, column).
  always_comb begin
    code_c = 4'h0;
    case ({r_q, c_q})
      4'b00_00: code_c = 4'h1;
      4'b00_01: code_c = 4'h2;
      4'b00_10: code_c = 4'h3;
      4'b00_11: code_c = 4'hA;
      4'b01_00: code_c = 4'h4;
      4'b01_01: code_c = 4'h5;
      4'b01_10: code_c = 4'h6;
      4'b01_11: code_c = 4'hB;
      4'b10_00: code_c = 4'h7;
      4'b10_01: code_c = 4'h8;
      4'b10_10: code_c = 4'h9;
      4'b10_11: code_c = 4'hC;
      4'b11_00: code_c = 4'hE;
      4'b11_01: code_c = 4'h0;
      4'b11_10: code_c = 4'hF;
      4'b11_11: code_c = 4'hD;
      default:  code_c = 4'h0;
    endcase
  end

  // Scan / debounce / hold / release-debounce sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      div_cnt   <= '0;
      db_cnt    <= '0;
      col       <= 4'b1110;
      r_q       <= 2'd0;
      c_q       <= 2'd0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (rs == 4'b1111) begin
              col <= {col[2:0], col[3]};
            end else begin
              r_q    <= row_idx_c;
              c_q    <= col_idx_c;
              db_cnt <= '0;
              state  <= DEBOUNCE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        DEBOUNCE: begin
          if (row_up_c) begin
            div_cnt <= '0;
            state   <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            state     <= HELD;
            key       <= code_c;
            key_valid <= 1'b1;
            digit_new <= code_c;
            digit_old <= digit_new;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end

        HELD: begin
          if (row_up_c) begin
            db_cnt <= '0;
            state  <= RELEASE;
          end
        end

        RELEASE: begin
          // A low sample here is contact bounce on the held key, not a new press.
          if (!row_up_c) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            div_cnt <= '0;
            state   <= SCAN;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end

        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad one column at a time and debounces presses and releases.
- Decodes each accepted press to a 4-bit hex value and shifts it into a two-digit history.
- The two history digits, digit_new and digit_old, are the s1/s2 inputs of the dual seven-segment display mux.
- Sits between the keypad pins and the display path; it is the producer of the digits the display mux consumes.

Parameters:
- SCAN_DIV, default 24000: clocks per column dwell. 0.5 ms at 48 MHz. Must be >= 3.
- DEBOUNCE_CYCLES, default 480000: consecutive stable clocks required to accept a press or a release. 10 ms at 48 MHz. Must be >= 2.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-low reset.
- row, input, 4: keypad rows, active-low, pulled up, asynchronous to clk.
- col, output, 4: keypad column drive, one-hot-low.
- key, output, 4: last accepted key code.
- key_valid, output, 1: single-cycle pulse when a press is accepted.
- digit_new, output, 4: most recent key; drives the display mux s1.
- digit_old, output, 4: previous key; drives the display mux s2.

Behaviour:
- Reset (reset=0 sampled on a clk edge) takes priority over every other event, including mid-debounce or mid-hold.
  - col=4'b1110, key=0, key_valid=0, digit_new=0, digit_old=0.
  - state=SCAN; divider and debounce counters cleared.
  - Synchronizer flops load 4'b1111.
- row passes through a 2-flop synchronizer to rs. All decisions below use rs, never raw row.
- Column index c is the position of the 0 in col. Row index r is the lowest-index 0 bit of rs (row priority 0 > 1 > 2 > 3).
- Key map, (r,c) -> code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- SCAN:
  - Divider counts 0..SCAN_DIV-1, then wraps to 0.
  - Only at the terminal count is rs evaluated.
  - If rs==4'b1111, col rotates left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Otherwise: latch r and c, hold col, clear the debounce counter, go to DEBOUNCE.
- DEBOUNCE:
  - col stays held. Each cycle, if rs[r]==1, return to SCAN with the divider cleared; col resumes rotation from the held column.
  - Otherwise the counter increments. On the cycle the counter reaches DEBOUNCE_CYCLES-1, go to HELD. On the same edge:
    - key <= map(r,c)
    - key_valid <= 1 for exactly one cycle
    - digit_old <= digit_new
    - digit_new <= map(r,c)
- HELD:
  - col stays held. Stay while rs[r]==0.
  - Other rows in the same column are ignored; no second key_valid is produced.
  - On rs[r]==1, clear the counter and go to RELEASE.
- RELEASE:
  - col stays held. Each cycle rs[r]==1 increments the counter.
  - If rs[r]==0, return to HELD (a bounce during release); no new key_valid.
  - When the counter reaches DEBOUNCE_CYCLES-1, go to SCAN with the divider cleared; col unchanged for that dwell.
- Latency: key_valid rises DEBOUNCE_CYCLES clocks after the SCAN-to-DEBOUNCE transition. From a raw row edge add 2 synchronizer cycles plus up to SCAN_DIV dwell.
- Outputs key, digit_new and digit_old change only on key_valid or reset.
- key_valid is never high for two consecutive cycles.
- Counters are sized ceil(log2(param)) bits and never exceed param-1.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
1. Reset, then row=4'b1111 for 40 clocks -> col cycles 1110, 1101, 1011, 0111, 1110 with each value held exactly 4 clocks; key_valid stays 0; digit_new=0, digit_old=0.
2. Hold row=4'b1101 while col=4'b1011 (r1,c2) for 30 clocks -> col freezes at 1011; key_valid is a single pulse; key=6, digit_new=6, digit_old=0.
3. Press r0,c0 (code 1), release for 20 clocks, then press r3,c1 (code 0) -> two pulses; after the second, digit_new=0 and digit_old=1.
4. Drive row low for 5 clocks during DEBOUNCE, then high -> no key_valid; col resumes rotation from the held column.
5. While HELD, toggle the row high for 3 clocks then low, then hold -> no extra pulse; after a full release of more than 8 high clocks the scan resumes.
6. Assert reset=0 for 1 clock mid-DEBOUNCE and mid-HELD -> next cycle col=1110, key_valid=0, key/digit_new/digit_old=0; a fresh press is then accepted normally.
